nco_spi_loader: RTL

- Upstream feeder for the NCO.
- Receives 24-bit tuning/wave-select words from the microcontroller over SPI (mode 0, MSB first) and presents each complete word on o_word.
- Each accepted word is announced with a write-enable pulse that drives the NCO's input latch directly.
- Echoes the last committed word on MISO so firmware can read it back.

---
 rtl/nco_spi_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/nco_spi_loader.sv
// SPI mode-0 slave that collects 24-bit NCO tuning words and
// strobes each accepted word into the NCO input latch.
module nco_spi_loader #(
    parameter int WORD_WIDTH   = 24,
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_spi_sclk,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_mosi,
    output logic                  o_spi_miso,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_latch_write_enable,
    output logic                  o_frame_error,
    input  logic                  i_clear_error
);

    localparam int CW = $clog2(WORD_WIDTH + 2);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_WIDTH + 1);
    localparam logic [PW-1:0] PULSE_LD = PW'(PULSE_CYCLES);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        RECEIVE,
        COMMIT
    } state_t;

    state_t state, state_n;

    logic [1:0] rst_q;
    logic       rst_n;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;

    logic [CW-1:0]         bit_cnt;
    logic                  ovf;
    logic [WORD_WIDTH-1:0] rx_sr;
    logic [WORD_WIDTH-1:0] miso_sr;
    logic [PW-1:0]         pulse_cnt;

    logic start, commit, set_err, shift_in, shift_out;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_q <= 2'b00;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    assign rst_n = rst_q[1];

    // CS sync resets low so a frame in flight at reset looks busy.
    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        commit    = 1'b0;
        set_err   = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        unique case (state)
            WAIT_IDLE: begin
                if (cs_s) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    start   = 1'b1;
                    state_n = RECEIVE;
                end
            end
            RECEIVE: begin
                shift_in  = sclk_rise & ~cs_s;
                shift_out = sclk_fall & ~cs_s;
                if (cs_rise) begin
                    if (bit_cnt == CNT_FULL && !ovf) begin
                        state_n = COMMIT;
                    end else begin
                        set_err = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            ovf     <= 1'b0;
            rx_sr   <= '0;
            miso_sr <= '0;
        end else begin
            if (start) begin
                bit_cnt <= '0;
                ovf     <= 1'b0;
                miso_sr <= o_word;
            end else begin
                if (shift_in) begin
                    rx_sr <= {rx_sr[WORD_WIDTH-2:0], mosi_s};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (bit_cnt == CNT_FULL) begin
                        ovf <= 1'b1;
                    end
                end
                if (shift_out) begin
                    miso_sr <= {miso_sr[WORD_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Pulse timer is free of the FSM; a new commit reloads it.
    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            o_word    <= '0;
            pulse_cnt <= '0;
        end else begin
            if (commit) begin
                o_word    <= rx_sr;
                pulse_cnt <= PULSE_LD;
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge rst_n) begin
        if (!rst_n) begin
            o_frame_error <= 1'b0;
        end else if (set_err) begin
            o_frame_error <= 1'b1;
        end else if (i_clear_error) begin
            o_frame_error <= 1'b0;
        end
    end

    assign o_latch_write_enable = (pulse_cnt != '0);
    assign o_spi_miso = (state == RECEIVE) & miso_sr[WORD_WIDTH-1];

endmodule
